// File: rtl/multicycle_mem_responder_if.sv
// Request/response bundle between the cache fill logic and the memory responder.
interface multicycle_mem_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [2:0]        rd_pending;

  // Requester side (cache fill FSM)
  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, rd_pending
  );

  // Responder side (memory)
  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, rd_pending
  );
endinterface

// File: rtl/multicycle_mem_responder.sv
// Fixed-latency, fully pipelined word memory responder.
// Reads snapshot the array at issue and emerge LATENCY cycles later as a
// one-cycle data_valid pulse; writes complete at the issuing edge.
module multicycle_mem_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned LATENCY = 4
) (
  input logic                    clk,
  input logic                    rst_n,  // active-high synchronous reset
  multicycle_mem_responder_if.slave bus
);
  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned PEND_W = 3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LATENCY-1:0] pipe_valid;
  logic [DATA_W-1:0]  pipe_data [LATENCY];
  logic [PEND_W-1:0]  pending;
  logic [MEM_AW-1:0]  word_idx;
  logic               rd_accept;
  logic               wr_accept;

  // Byte address to word index; bits above the implemented range alias
  assign word_idx  = bus.addr[MEM_AW:1];
  assign rd_accept = bus.enable & ~bus.wr;
  assign wr_accept = bus.enable & bus.wr;

  // Backing array: never cleared, writes suppressed while in reset
  always_ff @(posedge clk) begin
    if (!rst_n && wr_accept) begin
      mem[word_idx] <= bus.data_in;
    end
  end

  // Read pipeline: last stage doubles as the output register; data held at 0 when invalid
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pipe_valid <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_accept;
      pipe_data[0]  <= rd_accept ? mem[word_idx] : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  // Outstanding-read counter: +1 per accepted read, -1 per returned word
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending + PEND_W'(rd_accept) - PEND_W'(pipe_valid[LATENCY-1]);
    end
  end

  assign bus.data_valid = pipe_valid[LATENCY-1];
  assign bus.data_out   = pipe_data[LATENCY-1];
  assign bus.rd_pending = pending;
endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Bench for multicycle_mem_responder: three instances (LATENCY 4, 1, 7) share
// one stimulus stream and are checked every cycle against a queue-based model.
module tb_multicycle_mem_responder;
  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] din;

  int lat [3] = '{4, 1, 7};

  multicycle_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) if4 ();
  multicycle_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) if1 ();
  multicycle_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) if7 ();

  assign if4.enable = en;  assign if4.wr = wr;  assign if4.addr = addr;  assign if4.data_in = din;
  assign if1.enable = en;  assign if1.wr = wr;  assign if1.addr = addr;  assign if1.data_in = din;
  assign if7.enable = en;  assign if7.wr = wr;  assign if7.addr = addr;  assign if7.data_in = din;

  multicycle_mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_AW(10), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst), .bus(if4.slave));
  multicycle_mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_AW(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst), .bus(if1.slave));
  multicycle_mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_AW(10), .LATENCY(7)) dut7 (
    .clk(clk), .rst_n(rst), .bus(if7.slave));

  logic        dv   [3];
  logic [15:0] dout [3];
  logic [2:0]  pd   [3];
  assign dv[0] = if4.data_valid;  assign dout[0] = if4.data_out;  assign pd[0] = if4.rd_pending;
  assign dv[1] = if1.data_valid;  assign dout[1] = if1.data_out;  assign pd[1] = if1.rd_pending;
  assign dv[2] = if7.data_valid;  assign dout[2] = if7.data_out;  assign pd[2] = if7.rd_pending;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: array of words plus, per instance, a queue of reads due at a given edge
  logic [15:0] mm [1024];
  bit          mk [1024];
  ent_t        mq [3][$];
  int          edge_n = 0;
  bit          exp_v [3];
  logic [15:0] exp_d [3];
  bit          exp_k [3];
  int          exp_p [3];

  always @(posedge clk) begin
    int   idx;
    ent_t t;
    edge_n = edge_n + 1;
    idx = int'(addr[10:1]);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mq[k].delete();
      end else begin
        while (mq[k].size() > 0 && mq[k][0].due < edge_n) void'(mq[k].pop_front());
        if (en && !wr) begin
          t.due   = edge_n + lat[k] - 1;
          t.data  = mm[idx];
          t.known = mk[idx];
          mq[k].push_back(t);
        end
      end
    end
    if (!rst && en && wr) begin
      mm[idx] = din;
      mk[idx] = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      exp_v[k] = (mq[k].size() > 0) && (mq[k][0].due == edge_n);
      exp_d[k] = exp_v[k] ? mq[k][0].data : 16'h0000;
      exp_k[k] = exp_v[k] ? mq[k][0].known : 1'b1;
      exp_p[k] = mq[k].size();
    end
  end

  // Every-cycle comparison of all three instances against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("L%0d_valid", lat[k]), int'(dv[k]), int'(exp_v[k]));
        chk($sformatf("L%0d_pending", lat[k]), int'(pd[k]), exp_p[k]);
        if (exp_k[k]) chk($sformatf("L%0d_data", lat[k]), int'(dout[k]), int'(exp_d[k]));
      end
    end
  end

  int          pulses [3];
  logic [15:0] got [$];
  int          peak;

  // One cycle of stimulus; returns at the following negedge and logs outputs
  task automatic step(input bit e, input bit w, input logic [15:0] a, input logic [15:0] d);
    en = e; wr = w; addr = a; din = d;
    @(negedge clk);
    for (int k = 0; k < 3; k++) if (dv[k]) pulses[k]++;
    if (dv[0]) got.push_back(dout[0]);
    if (int'(pd[0]) > peak) peak = int'(pd[0]);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    int rd_cnt;
    logic [15:0] a;
    bit e;
    bit w;
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
    @(negedge clk);
    idle(1);
    rst = 1'b0;
    chk_on = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("idle_valid", int'(dv[0]), 0);
      chk("idle_data", int'(dout[0]), 0);
      chk("idle_pending", int'(pd[0]), 0);
    end

    // Single write then read, LATENCY 4
    got.delete();
    step(1'b1, 1'b1, 16'h1230, 16'hBEEF);
    step(1'b1, 1'b0, 16'h1230, 16'h0000);
    chk("t2_pending", int'(pd[0]), 1);
    chk("t2_valid", int'(dv[0]), 0);
    idle(1);
    chk("t3_pending", int'(pd[0]), 1);
    idle(1);
    chk("t4_valid", int'(dv[0]), 0);
    idle(1);
    chk("t5_valid", int'(dv[0]), 1);
    chk("t5_data", int'(dout[0]), 16'hBEEF);
    chk("t5_pending", int'(pd[0]), 1);
    idle(1);
    chk("t6_valid", int'(dv[0]), 0);
    chk("t6_data", int'(dout[0]), 0);
    chk("t6_pending", int'(pd[0]), 0);
    idle(4);
    chk("single_pulse_count", got.size(), 1);

    // Burst of eight writes then eight back-to-back reads
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(16'h1230 + 2 * i), 16'(16'hA000 + i));
    got.delete();
    peak = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(16'h1230 + 2 * i), 16'h0000);
    idle(8);
    chk("burst_count", got.size(), 8);
    if (got.size() == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("burst_data%0d", i), int'(got[i]), 16'hA000 + i);
    chk("burst_peak_pending", peak, 4);

    // Held reads, overwrite after issue, aliased byte address
    step(1'b1, 1'b1, 16'h0040, 16'h1111);
    got.delete();
    repeat (4) step(1'b1, 1'b0, 16'h0040, 16'h0000);
    step(1'b1, 1'b1, 16'h0040, 16'h2222);
    step(1'b1, 1'b0, 16'h0041, 16'h0000);
    idle(8);
    chk("hold_count", got.size(), 5);
    if (got.size() == 5) begin
      for (int i = 0; i < 4; i++) chk($sformatf("hold_old%0d", i), int'(got[i]), 16'h1111);
      chk("hold_new", int'(got[4]), 16'h2222);
    end

    // Reset with reads in flight; a write during reset is dropped
    step(1'b1, 1'b0, 16'h1230, 16'h0000);
    step(1'b1, 1'b0, 16'h1232, 16'h0000);
    step(1'b1, 1'b0, 16'h1234, 16'h0000);
    idle(1);
    rst = 1'b1;
    step(1'b1, 1'b1, 16'h1236, 16'hDEAD);
    rst = 1'b0;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("rst_valid", int'(dv[0]), 0);
      chk("rst_pending", int'(pd[0]), 0);
    end
    chk("rst_l7_pending", int'(pd[2]), 0);
    step(1'b1, 1'b0, 16'h1230, 16'h0000);
    step(1'b1, 1'b0, 16'h0040, 16'h0000);
    step(1'b1, 1'b0, 16'h1236, 16'h0000);
    idle(8);
    chk("rst_readback_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("rst_readback0", int'(got[0]), 16'hA000);
      chk("rst_readback1", int'(got[1]), 16'h2222);
      chk("rst_readback2", int'(got[2]), 16'hA003);
    end

    // Random traffic across all three latencies
    for (int k = 0; k < 3; k++) pulses[k] = 0;
    rd_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 2) == 0);
      a = 16'($urandom) & 16'hF83F;
      if (e && !w) rd_cnt++;
      step(e, w, a, 16'($urandom));
    end
    idle(10);
    for (int k = 0; k < 3; k++) chk($sformatf("L%0d_pulse_count", lat[k]), pulses[k], rd_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
